// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data, memory and stall signals around mem_port_arbiter.
// slave: the arbiter's view. master: the surrounding pipeline/memory view.
interface mem_port_arbiter_if;
    // Fetch stage
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush_F;
    logic [31:0] if_rdata;
    logic        if_valid;
    // Memory stage
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_size;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    // Unified memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // Pipeline control
    logic        stall_F;
    logic        stall_M;
    logic        err;

    modport slave (
        input  if_req, if_addr, flush_F,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_size,
        input  mem_rdata, mem_ack,
        output if_rdata, if_valid, dm_rdata, dm_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output stall_F, stall_M, err
    );

    modport master (
        output if_req, if_addr, flush_F,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_size,
        output mem_rdata, mem_ack,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  stall_F, stall_M, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one single-ported memory,
// sequences each access through the req/ack handshake and stalls the waiter.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_BUSY  = 2'd1,
        INSTR_BUSY = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]      mem_size_q, mem_size_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            dm_valid_q, dm_valid_d;
    logic            discard_q, discard_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            last_data_q, last_data_d;

    logic            if_elig, dm_elig, grant_if, grant_dm;

    // Alternating-priority arbitration; a requester in its valid cycle sits out
    assign if_elig  = bus.if_req & ~if_valid_q;
    assign dm_elig  = bus.dm_req & ~dm_valid_q;
    assign grant_if = if_elig & (~dm_elig | last_data_q);
    assign grant_dm = dm_elig & ~grant_if;

    // Next-state, transaction latching, read-data capture and watchdog
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        last_data_d = last_data_q;

        unique case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d     = INSTR_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_size_d  = SIZE_WORD;
                    discard_d   = bus.flush_F;
                    cnt_d       = '0;
                    last_data_d = 1'b0;
                end else if (grant_dm) begin
                    state_d     = DATA_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_size_d  = bus.dm_size;
                    discard_d   = 1'b0;
                    cnt_d       = '0;
                    last_data_d = 1'b1;
                end
            end
            DATA_BUSY: begin
                if (bus.mem_ack) begin
                    dm_rdata_d = bus.mem_rdata;
                    dm_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q < CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            INSTR_BUSY: begin
                // A redirect cannot abort the memory, only drop the result
                if (bus.flush_F) begin
                    discard_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    if_rdata_d = bus.mem_rdata;
                    if_valid_d = ~(discard_q | bus.flush_F);
                    discard_d  = 1'b0;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q < CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && !bus.mem_ack && cnt_d == CW'(TIMEOUT)) begin
            err_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            last_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            last_data_q <= last_data_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.err       = err_q;

    // Stalls are combinational so the pipeline freezes in the request cycle;
    // a discarded fetch does not stall, the redirected PC waits for IDLE.
    assign bus.stall_F = bus.if_req & ~if_valid_q & ~bus.flush_F & ~discard_q;
    assign bus.stall_M = bus.dm_req & ~dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-data scoreboard.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   ack_delay = 0;
    bit   ack_en = 1'b1;
    int   wait_cnt = 0;

    function automatic logic [31:0] model(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory responder: ack after ack_delay cycles of mem_req, data = model(addr)
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.mem_req && ack_en) begin
                if (wait_cnt == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = model(bus.mem_addr);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard: every valid pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.if_valid || bus.dm_valid)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {30'b0, bus.if_valid, bus.dm_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_kind", {31'b0, bus.dm_valid}, {31'b0, e.is_data});
                    chk("rdata", e.is_data ? bus.dm_rdata : bus.if_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_req"},   {31'b0, bus.mem_req},  32'h0);
        chk({tag, "_mem_we"},    {31'b0, bus.mem_we},   32'h0);
        chk({tag, "_mem_addr"},  bus.mem_addr,          32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,         32'h0);
        chk({tag, "_mem_size"},  {30'b0, bus.mem_size}, 32'h0);
        chk({tag, "_if_valid"},  {31'b0, bus.if_valid}, 32'h0);
        chk({tag, "_dm_valid"},  {31'b0, bus.dm_valid}, 32'h0);
        chk({tag, "_if_rdata"},  bus.if_rdata,          32'h0);
        chk({tag, "_dm_rdata"},  bus.dm_rdata,          32'h0);
        chk({tag, "_err"},       {31'b0, bus.err},      32'h0);
        chk({tag, "_stall_M"},   {31'b0, bus.stall_M},  32'h0);
    endtask

    initial begin
        int  n_valid;
        bit  prev_dm;
        bit  prev_if;

        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.flush_F  = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.dm_size  = 2'b10;

        repeat (2) smp();
        chk_reset_vals("rst");
        chk("rst_stall_F", {31'b0, bus.stall_F}, 32'h0);
        tick();
        rst_n = 1'b1;

        // Fetch only, ack in the first mem_req cycle
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        exp_q.push_back('{1'b0, model(32'h10)});
        smp();
        chk("f_c0_stall_F", {31'b0, bus.stall_F}, 32'h1);
        chk("f_c0_mem_req", {31'b0, bus.mem_req}, 32'h0);
        tick(); smp();
        chk("f_c1_mem_req",  {31'b0, bus.mem_req},  32'h1);
        chk("f_c1_mem_addr", bus.mem_addr,          32'h10);
        chk("f_c1_mem_we",   {31'b0, bus.mem_we},   32'h0);
        chk("f_c1_mem_size", {30'b0, bus.mem_size}, 32'h2);
        chk("f_c1_stall_F",  {31'b0, bus.stall_F},  32'h1);
        tick(); smp();
        chk("f_c2_if_valid", {31'b0, bus.if_valid}, 32'h1);
        chk("f_c2_stall_F",  {31'b0, bus.stall_F},  32'h0);
        bus.if_req = 1'b0;
        tick(); smp();
        chk("f_c3_mem_req",  {31'b0, bus.mem_req},  32'h0);
        chk("f_c3_if_valid", {31'b0, bus.if_valid}, 32'h0);

        // Both requesters held: data, fetch, data, fetch
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h100;
        bus.dm_size = 2'b10;
        exp_q.push_back('{1'b1, model(32'h100)});
        exp_q.push_back('{1'b0, model(32'h40)});
        exp_q.push_back('{1'b1, model(32'h100)});
        exp_q.push_back('{1'b0, model(32'h40)});
        n_valid = 0;
        prev_dm = 1'b0;
        prev_if = 1'b0;
        for (int c = 0; c < 24 && n_valid < 4; c++) begin
            smp();
            if (prev_dm) begin
                chk("arb_after_dm_req",  {31'b0, bus.mem_req}, 32'h1);
                chk("arb_after_dm_addr", bus.mem_addr,         32'h40);
            end
            if (prev_if) begin
                chk("arb_after_if_req",  {31'b0, bus.mem_req}, 32'h1);
                chk("arb_after_if_addr", bus.mem_addr,         32'h100);
            end
            prev_dm = bus.dm_valid;
            prev_if = bus.if_valid && (n_valid < 3);
            if (bus.if_valid || bus.dm_valid) begin
                n_valid++;
                if (n_valid == 4) begin
                    bus.if_req = 1'b0;
                    bus.dm_req = 1'b0;
                end
            end
            tick();
        end
        chk("arb_valid_count", 32'(n_valid), 32'd4);
        smp();
        chk("arb_end_mem_req", {31'b0, bus.mem_req}, 32'h0);

        // Byte store, ack one cycle late
        tick();
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_size  = 2'b00;
        bus.dm_addr  = 32'h20;
        bus.dm_wdata = 32'hAB;
        ack_delay    = 1;
        exp_q.push_back('{1'b1, model(32'h20)});
        smp();
        chk("st_c0_stall_M", {31'b0, bus.stall_M}, 32'h1);
        tick(); smp();
        chk("st_c1_mem_req",   {31'b0, bus.mem_req},  32'h1);
        chk("st_c1_mem_we",    {31'b0, bus.mem_we},   32'h1);
        chk("st_c1_mem_size",  {30'b0, bus.mem_size}, 32'h0);
        chk("st_c1_mem_wdata", bus.mem_wdata,         32'hAB);
        chk("st_c1_mem_addr",  bus.mem_addr,          32'h20);
        chk("st_c1_stall_M",   {31'b0, bus.stall_M},  32'h1);
        tick(); smp();
        chk("st_c2_dm_valid", {31'b0, bus.dm_valid}, 32'h0);
        chk("st_c2_stall_M",  {31'b0, bus.stall_M},  32'h1);
        tick(); smp();
        chk("st_c3_dm_valid", {31'b0, bus.dm_valid}, 32'h1);
        chk("st_c3_stall_M",  {31'b0, bus.stall_M},  32'h0);
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        ack_delay  = 0;

        // Stray ack while idle
        tick(); smp();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        tick(); smp();
        chk("idle_ack_if_valid", {31'b0, bus.if_valid}, 32'h0);
        chk("idle_ack_dm_valid", {31'b0, bus.dm_valid}, 32'h0);
        chk("idle_ack_mem_req",  {31'b0, bus.mem_req},  32'h0);

        // Flush the cycle after a fetch grant; ack three cycles later
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
        ack_delay   = 3;
        smp();
        chk("fl_c0_stall_F", {31'b0, bus.stall_F}, 32'h1);
        tick();
        bus.flush_F = 1'b1;
        bus.if_addr = 32'h200;
        smp();
        chk("fl_c1_stall_F",  {31'b0, bus.stall_F}, 32'h0);
        chk("fl_c1_mem_addr", bus.mem_addr,         32'h80);
        tick();
        bus.flush_F = 1'b0;
        exp_q.push_back('{1'b0, model(32'h200)});
        smp();
        chk("fl_c2_stall_F", {31'b0, bus.stall_F}, 32'h0);
        tick(); smp();
        chk("fl_c3_stall_F",  {31'b0, bus.stall_F},  32'h0);
        chk("fl_c3_if_valid", {31'b0, bus.if_valid}, 32'h0);
        tick(); smp();
        chk("fl_c4_stall_F", {31'b0, bus.stall_F}, 32'h0);
        chk("fl_c4_mem_req", {31'b0, bus.mem_req}, 32'h1);
        tick();
        ack_delay = 0;
        smp();
        chk("fl_c5_if_valid", {31'b0, bus.if_valid}, 32'h0);
        chk("fl_c5_stall_F",  {31'b0, bus.stall_F},  32'h1);
        chk("fl_c5_mem_req",  {31'b0, bus.mem_req},  32'h0);
        tick(); smp();
        chk("fl_c6_mem_addr", bus.mem_addr,         32'h200);
        chk("fl_c6_mem_req",  {31'b0, bus.mem_req}, 32'h1);
        tick(); smp();
        chk("fl_c7_if_valid", {31'b0, bus.if_valid}, 32'h1);
        bus.if_req = 1'b0;

        // Memory never acks: watchdog, then asynchronous reset mid-wait
        tick();
        ack_en       = 1'b0;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h300;
        bus.dm_size  = 2'b10;
        smp();
        for (int k = 1; k <= 64; k++) begin
            tick(); smp();
            chk("to_err_early", {31'b0, bus.err}, 32'h0);
        end
        tick(); smp();
        chk("to_err_set", {31'b0, bus.err}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick(); smp();
            chk("to_err_sticky", {31'b0, bus.err},     32'h1);
            chk("to_still_req",  {31'b0, bus.mem_req}, 32'h1);
        end
        @(posedge clk);
        #3;
        rst_n      = 1'b0;
        bus.dm_req = 1'b0;
        #1;
        chk_reset_vals("arst");
        #10;
        rst_n  = 1'b1;
        ack_en = 1'b1;
        tick(); smp();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
